// File: rtl/exec_wb_ctrl.sv
// rtl/exec_wb_ctrl.sv - four-phase read/execute/writeback controller for a 16-entry register file
module exec_wb_ctrl #(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [3:0]      in_rd,
    input  logic [3:0]      in_ra,
    input  logic [3:0]      in_rb,
    input  logic [16*N-1:0] rf_bus,
    output logic            w,
    output logic [3:0]      select_register,
    output logic [N-1:0]    s,
    output logic            done,
    output logic            zero,
    output logic            carry
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [3:0]    rd_q, ra_q, rb_q;
    logic [N-1:0]  a_q, b_q;
    logic [N-1:0]  alu_res;
    logic          alu_c;
    logic [N:0]    sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        w         = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = READ;
            end
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                w         = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SUB borrow falls out of the extra top bit of the widened difference
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            3'b000: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
            end
            3'b001: begin
                sum     = {1'b0, a_q} - {1'b0, b_q};
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
            end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b100: alu_res = a_q ^ b_q;
            3'b101: begin
                alu_res = {a_q[N-2:0], 1'b0};
                alu_c   = a_q[N-1];
            end
            3'b110: begin
                alu_res = {1'b0, a_q[N-1:1]};
                alu_c   = a_q[0];
            end
            default: alu_res = a_q;
        endcase
    end

    // s doubles as the result register; it and select_register hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q            <= '0;
            rd_q            <= '0;
            ra_q            <= '0;
            rb_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            s               <= '0;
            select_register <= '0;
            zero            <= 1'b0;
            carry           <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                op_q <= in_op;
                rd_q <= in_rd;
                ra_q <= in_ra;
                rb_q <= in_rb;
            end
            if (state == READ) begin
                a_q <= rf_bus[int'(ra_q)*N +: N];
                b_q <= rf_bus[int'(rb_q)*N +: N];
            end
            if (state == EXEC) begin
                s               <= alu_res;
                select_register <= rd_q;
                zero            <= (alu_res == '0);
                carry           <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_exec_wb_ctrl.sv
// tb/tb_exec_wb_ctrl.sv - directed self-checking bench for exec_wb_ctrl
module tb_exec_wb_ctrl;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [3:0]      in_rd, in_ra, in_rb;
    logic [16*N-1:0] rf_bus;
    logic            w;
    logic [3:0]      select_register;
    logic [N-1:0]    s;
    logic            done, zero, carry;

    logic [N-1:0]    rf [16];
    logic            ld_en;
    logic [3:0]      ld_idx;
    logic [N-1:0]    ld_val;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              w_count  = 0;

    always #5 clk = ~clk;

    exec_wb_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .rf_bus(rf_bus), .w(w), .select_register(select_register), .s(s),
        .done(done), .zero(zero), .carry(carry)
    );

    for (genvar g = 0; g < 16; g++) begin : g_bus
        assign rf_bus[g*N +: N] = rf[g];
    end

    // register file environment: DUT writes, plus bench preloads while idle
    always @(posedge clk) begin
        if (w) begin
            rf[select_register] <= s;
            w_count <= w_count + 1;
        end else if (ld_en) begin
            rf[ld_idx] <= ld_val;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] idx, input logic [N-1:0] val);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
        @(posedge clk); #1;
        ld_en  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("issue_ready", in_ready, 1);
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'b111; in_rd = 4'hf; in_ra = 4'hf; in_rb = 4'hf;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] rd,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [N-1:0] exp_s, input logic exp_z, input logic exp_c);
        issue(op, rd, ra, rb);
        check_eq({tag, ".read_w"}, w, 0);
        check_eq({tag, ".read_ready"}, in_ready, 0);
        @(posedge clk); #1;
        check_eq({tag, ".exec_w"}, {w, done}, 0);
        @(posedge clk); #1;
        check_eq({tag, ".wb_w"}, w, 1);
        check_eq({tag, ".wb_done"}, done, 1);
        check_eq({tag, ".sel"}, select_register, rd);
        check_eq({tag, ".s"}, s, exp_s);
        check_eq({tag, ".zero"}, zero, exp_z);
        check_eq({tag, ".carry"}, carry, exp_c);
        @(posedge clk); #1;
        check_eq({tag, ".post_wd"}, {w, done}, 0);
        check_eq({tag, ".post_ready"}, in_ready, 1);
        check_eq({tag, ".post_s_hold"}, s, exp_s);
        check_eq({tag, ".rf"}, rf[rd], exp_s);
    endtask

    initial begin
        int  cyc;
        logic acc;
        int  wc;
        rst = 1'b1; in_valid = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
        in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", {w, done, zero, carry, select_register, s}, 0);
        check_eq("reset_ready", in_ready, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        load(4'd1, 16'd5); load(4'd2, 16'd3);
        run_op("add", 3'b000, 4'd3, 4'd1, 4'd2, 16'd8, 1'b0, 1'b0);
        load(4'd1, 16'd3); load(4'd2, 16'd5);
        run_op("sub_borrow", 3'b001, 4'd4, 4'd1, 4'd2, 16'hFFFE, 1'b0, 1'b1);
        load(4'd1, 16'hFFFF); load(4'd2, 16'h0001);
        run_op("add_wrap", 3'b000, 4'd5, 4'd1, 4'd2, 16'h0000, 1'b1, 1'b1);
        load(4'd1, 16'h8001);
        run_op("shl", 3'b101, 4'd5, 4'd1, 4'd2, 16'h0002, 1'b0, 1'b1);
        load(4'd1, 16'h0001);
        run_op("shr", 3'b110, 4'd5, 4'd1, 4'd2, 16'h0000, 1'b1, 1'b1);
        load(4'd1, 16'hF0F0); load(4'd2, 16'hFF00);
        run_op("and", 3'b010, 4'd7, 4'd1, 4'd2, 16'hF000, 1'b0, 1'b0);
        run_op("or",  3'b011, 4'd7, 4'd1, 4'd2, 16'hFFF0, 1'b0, 1'b0);
        run_op("xor", 3'b100, 4'd7, 4'd1, 4'd2, 16'h0FF0, 1'b0, 1'b0);
        run_op("sub_eq", 3'b001, 4'd7, 4'd2, 4'd2, 16'h0000, 1'b1, 1'b0);
        load(4'd9, 16'h0003);
        run_op("rd_eq_ra", 3'b000, 4'd9, 4'd9, 4'd9, 16'h0006, 1'b0, 1'b0);

        // back-to-back: valid held high, second instruction reads first's result
        load(4'd1, 16'd5); load(4'd2, 16'd3); load(4'd6, 16'h0000);
        in_valid = 1'b1; in_op = 3'b000; in_rd = 4'd3; in_ra = 4'd1; in_rb = 4'd2;
        @(posedge clk); #1;
        in_op = 3'b111; in_rd = 4'd6; in_ra = 4'd3; in_rb = 4'd0;
        cyc = 0; acc = 1'b0;
        while (!acc && cyc < 10) begin
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("b2b.spacing", cyc, 4);
        check_eq("b2b.rf3", rf[3], 16'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("b2b.wb", {w, select_register, s}, {1'b1, 4'd6, 16'd8});
        @(posedge clk); #1;
        check_eq("b2b.rf6", rf[6], 16'd8);

        // reset during EXEC aborts the write
        load(4'd1, 16'd7); load(4'd2, 16'd1); load(4'd8, 16'h1234);
        issue(3'b000, 4'd8, 4'd1, 4'd2);
        @(posedge clk); #1;
        wc = w_count;
        @(negedge clk); rst = 1'b1; #1;
        check_eq("rst_mid.outs", {w, done, zero, carry, select_register, s}, 0);
        check_eq("rst_mid.ready", in_ready, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid.ready_after", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mid.no_write", w_count, wc);
        check_eq("rst_mid.rf8", rf[8], 16'h1234);
        run_op("post_rst_mov", 3'b111, 4'd8, 4'd1, 4'd2, 16'd7, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_wb_ctrl.md
EXEC_WB_CTRL -- requirements
Module: exec_wb_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, setting data word width.
REQ-002 SHALL have clk, input, 1, rising-edge clock.
REQ-003 SHALL have rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have in_valid, input, 1, instruction offered.
REQ-005 SHALL have in_ready, output, 1, instruction accepted when in_valid and in_ready are both high at a rising clk edge.
REQ-006 SHALL have in_op, input, 3, opcode.
REQ-007 SHALL have in_rd, in_ra and in_rb, inputs, 4 bits each: destination, operand A and operand B indices (index 0 = register 1 … index 15 = register 16).
REQ-008 SHALL have rf_bus, input, 16*N, register-file contents; register k+1 at bits [(k+1)*N-1 : k*N].
REQ-009 SHALL have w, output, 1, register-file write enable.
REQ-010 SHALL have select_register, output, 4, write index, same encoding as in_rd.
REQ-011 SHALL have s, output, N, write data.
REQ-012 SHALL have done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have zero and carry, outputs, 1 each, result flags.

Function
REQ-014 SHALL implement FSM states IDLE, READ, EXEC and WB, each taking exactly one cycle except IDLE.
- IDLE→READ on handshake at edge E0.
- READ→EXEC at E1.
- EXEC→WB at E2.
- WB→IDLE at E3.
REQ-015 SHALL drive in_ready high only in IDLE; in_ready is decoded combinationally from the state register.
REQ-016 SHALL latch in_op, in_rd, in_ra and in_rb at E0.
REQ-017 SHALL latch operands A = rf_bus[ra] and B = rf_bus[rb] at E1, sampled during the READ cycle.
REQ-018 SHALL compute the result at E2 into an N-bit result register, by opcode:
- 000 ADD: A+B.
- 001 SUB: A−B.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 SHL: A<<1.
- 110 SHR: A>>1, logical.
- 111 MOV: A.
B is ignored for opcodes 101–111.
REQ-019 SHALL keep all arithmetic modulo 2^N, unsigned; no saturation.
REQ-020 SHALL update carry at E2:
- ADD: carry-out.
- SUB: borrow, 1 iff A<B unsigned.
- SHL: old A[N-1].
- SHR: old A[0].
- Logic ops and MOV: 0.
REQ-021 SHALL update zero at E2 as (result == 0).
REQ-022 SHALL hold zero and carry until the next E2.
REQ-023 SHALL drive w=1, select_register=rd, s=result and done=1 during the WB cycle only, so the register file writes at E3.
REQ-024 SHALL keep w=0 and done=0 outside WB, while select_register and s hold their last values.
REQ-025 SHALL issue exactly one write per accepted instruction; minimum instruction spacing is 4 cycles, with the next accept possible at E3+1 edge.
REQ-026 SHALL need no forwarding: an instruction accepted after a write reads the updated register value, because E1 of that instruction follows the write edge E3 of the previous one.
REQ-027 SHALL ignore in_valid and all in_* inputs outside IDLE.
REQ-028 SHALL allow rd equal to ra or rb; operands are already latched before the write.

Reset
REQ-029 SHALL on rst asynchronously force:
- state IDLE;
- w=0, done=0;
- select_register=0, s=0;
- zero=0, carry=0;
- internal latches 0;
- in_ready=1.
REQ-030 SHALL abort any in-flight instruction when rst is asserted mid-operation, with no write issued; the first accept is possible at the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover ADD: r2=5, r3=3; op 000, rd=3, ra=1, rb=2 → w high exactly in cycle after E2, select_register=4'b0011, s=8, zero=0, carry=0, done pulse 1 cycle.
REQ-032 SHALL cover SUB borrow: r2=3, r3=5; op 001, ra=1, rb=2 → s=16'hFFFE, carry=1, zero=0.
REQ-033 SHALL cover ADD wrap: A=16'hFFFF, B=16'h0001 → s=0, zero=1, carry=1.
REQ-034 SHALL cover shifts:
- SHL A=16'h8001 → s=16'h0002, carry=1.
- SHR A=16'h0001 → s=0, zero=1, carry=1.
REQ-035 SHALL cover back-to-back issue: in_valid held high; instr1 ADD into index 3, instr2 MOV ra=3 → instr2 accepted 4 cycles after instr1 and writes instr1's result.
REQ-036 SHALL cover reset mid-operation: rst pulsed during EXEC → no w pulse, all outputs at reset values, in_ready=1 after release.
